// File: rtl/ft833_bus_decoder.sv
// Programmable-window chip-select decoder with per-channel wait states, ack handshake,
// read-data steering and a timeout that turns a stuck access into a one-cycle bus error.
module ft833_bus_decoder #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned AW         = 26,
    parameter int unsigned DW         = 8,
    parameter int unsigned WSW        = 4,
    parameter int unsigned TMO        = 255,
    parameter int unsigned DEFAULT_WS = 0,
    localparam int unsigned CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vda,
    input  logic              rw,
    input  logic [AW-1:0]     ad,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [AW-1:0]     cfg_base,
    input  logic [AW-1:0]     cfg_mask,
    input  logic [WSW-1:0]    cfg_ws,
    input  logic              cfg_en,
    output logic [NCH-1:0]    cs,
    input  logic [NCH-1:0]    ch_ack,
    input  logic [NCH*DW-1:0] ch_dat,
    input  logic [DW-1:0]     ext_dat,
    output logic [DW-1:0]     dat_o,
    output logic              rdy,
    output logic              err,
    output logic [AW-1:0]     err_ad
);
    localparam logic [15:0]    TmoCnt = 16'(TMO);
    localparam logic [WSW-1:0] WsRst  = WSW'(DEFAULT_WS);

    typedef enum logic [1:0] {StIdle, StWait, StDone, StErr} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  base_q [NCH];
    logic [AW-1:0]  base_d [NCH];
    logic [AW-1:0]  mask_q [NCH];
    logic [AW-1:0]  mask_d [NCH];
    logic [WSW-1:0] ws_q   [NCH];
    logic [WSW-1:0] ws_d   [NCH];
    logic [NCH-1:0] en_q, en_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [WSW-1:0] wcnt_q, wcnt_d;
    logic [15:0]    tcnt_q, tcnt_d;
    logic [DW-1:0]  dat_r_q, dat_r_d;
    logic [AW-1:0]  ad_q, ad_d;
    logic           rw_q, rw_d;
    logic [AW-1:0]  err_ad_q, err_ad_d;

    logic           hit;
    logic [CW-1:0]  hit_idx;
    logic           sel_ack;
    logic [DW-1:0]  sel_dat;
    logic [NCH-1:0] ch_onehot;

    always_comb begin
        base_d = base_q;
        mask_d = mask_q;
        ws_d   = ws_q;
        en_d   = en_q;
        if (cfg_we && (32'(cfg_ch) < NCH)) begin
            base_d[cfg_ch] = cfg_base;
            mask_d[cfg_ch] = cfg_mask;
            ws_d[cfg_ch]   = cfg_ws;
            en_d[cfg_ch]   = cfg_en;
        end
    end

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (en_q[i] && (((ad ^ base_q[i]) & mask_q[i]) == '0)) begin
                hit     = 1'b1;
                hit_idx = CW'(i);
            end
        end
    end

    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (ch_q == CW'(i)) begin
                sel_ack = ch_ack[i];
                sel_dat = ch_dat[i*DW +: DW];
            end
        end
    end

    assign ch_onehot = NCH'(1) << ch_q;
    assign err_ad    = err_ad_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        wcnt_d   = wcnt_q;
        tcnt_d   = tcnt_q;
        dat_r_d  = dat_r_q;
        ad_d     = ad_q;
        rw_d     = rw_q;
        err_ad_d = err_ad_q;
        cs       = '0;
        rdy      = 1'b1;
        err      = 1'b0;
        dat_o    = '0;
        unique case (state_q)
            StIdle: begin
                dat_o = rw ? ext_dat : '0;
                if (vda && hit) begin
                    rdy     = 1'b0;
                    ch_d    = hit_idx;
                    wcnt_d  = ws_q[hit_idx];
                    tcnt_d  = '0;
                    ad_d    = ad;
                    rw_d    = rw;
                    state_d = StWait;
                end
            end
            StWait: begin
                cs     = ch_onehot;
                rdy    = 1'b0;
                wcnt_d = (wcnt_q != '0) ? wcnt_q - 1'b1 : '0;
                tcnt_d = tcnt_q + 16'd1;
                // Abandoned access, then ack, then timeout: ack wins a tie with timeout.
                if (!vda) begin
                    state_d = StIdle;
                end else if ((wcnt_q == '0) && sel_ack) begin
                    dat_r_d = rw_q ? sel_dat : '0;
                    state_d = StDone;
                end else if (tcnt_q == TmoCnt) begin
                    err_ad_d = ad_q;
                    state_d  = StErr;
                end
            end
            StDone: begin
                cs      = ch_onehot;
                dat_o   = dat_r_q;
                state_d = StIdle;
            end
            StErr: begin
                err     = 1'b1;
                dat_o   = rw_q ? '1 : '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            wcnt_q   <= '0;
            tcnt_q   <= '0;
            dat_r_q  <= '0;
            ad_q     <= '0;
            rw_q     <= 1'b0;
            err_ad_q <= '0;
            en_q     <= '0;
            for (int i = 0; i < int'(NCH); i++) begin
                base_q[i] <= '0;
                mask_q[i] <= '0;
                ws_q[i]   <= WsRst;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            wcnt_q   <= wcnt_d;
            tcnt_q   <= tcnt_d;
            dat_r_q  <= dat_r_d;
            ad_q     <= ad_d;
            rw_q     <= rw_d;
            err_ad_q <= err_ad_d;
            en_q     <= en_d;
            base_q   <= base_d;
            mask_q   <= mask_d;
            ws_q     <= ws_d;
        end
    end

endmodule

// File: tb/tb_ft833_bus_decoder.sv
// Bench for ft833_bus_decoder: reset vector table, directed corner sequences and randomized
// accesses predicted from the window rules and the ack pattern of each access.
module tb_ft833_bus_decoder;
    localparam int NCH = 4;
    localparam int AW  = 26;
    localparam int DW  = 8;
    localparam int WSW = 4;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vda = 1'b0;
    logic              rw = 1'b0;
    logic [AW-1:0]     ad = '0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_ch = '0;
    logic [AW-1:0]     cfg_base = '0;
    logic [AW-1:0]     cfg_mask = '0;
    logic [WSW-1:0]    cfg_ws = '0;
    logic              cfg_en = 1'b0;
    logic [NCH-1:0]    cs;
    logic [NCH-1:0]    ch_ack = '0;
    logic [NCH*DW-1:0] ch_dat;
    logic [DW-1:0]     ext_dat = '0;
    logic [DW-1:0]     dat_o;
    logic              rdy;
    logic              err;
    logic [AW-1:0]     err_ad;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0]  m_base [NCH];
    logic [AW-1:0]  m_mask [NCH];
    logic [WSW-1:0] m_ws   [NCH];
    logic           m_en   [NCH];
    logic [DW-1:0]  m_dat  [NCH];

    assign ch_dat = {m_dat[3], m_dat[2], m_dat[1], m_dat[0]};

    ft833_bus_decoder #(
        .NCH(NCH), .AW(AW), .DW(DW), .WSW(WSW), .TMO(TMO), .DEFAULT_WS(0)
    ) dut (
        .clk(clk), .rst(rst), .vda(vda), .rw(rw), .ad(ad),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
        .cfg_ws(cfg_ws), .cfg_en(cfg_en), .cs(cs), .ch_ack(ch_ack), .ch_dat(ch_dat),
        .ext_dat(ext_dat), .dat_o(dat_o), .rdy(rdy), .err(err), .err_ad(err_ad)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          vda;
        logic          rw;
        logic [AW-1:0] ad;
        logic [DW-1:0] ext;
        logic [3:0]    exp_cs;
        logic          exp_rdy;
        logic [DW-1:0] exp_dat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_base[i] = '0;
            m_mask[i] = '0;
            m_ws[i]   = '0;
            m_en[i]   = 1'b0;
        end
    endtask

    function automatic int model_hit(input logic [AW-1:0] a);
        for (int i = 0; i < NCH; i++)
            if (m_en[i] && (((a ^ m_base[i]) & m_mask[i]) == '0)) return i;
        return -1;
    endfunction

    task automatic cfg_write(input int c, input logic [AW-1:0] b, input logic [AW-1:0] m,
                             input logic [WSW-1:0] w, input logic e);
        vda = 1'b0; cfg_we = 1'b1; cfg_ch = 2'(c);
        cfg_base = b; cfg_mask = m; cfg_ws = w; cfg_en = e;
        tick();
        cfg_we = 1'b0;
        m_base[c] = b; m_mask[c] = m; m_ws[c] = w; m_en[c] = e;
    endtask

    // ack_bits[w] is the selected channel's ack during the w-th WAIT cycle.
    task automatic run_access(input logic [AW-1:0] a, input logic r, input logic [15:0] ack_bits);
        int   idx;
        int   k;
        int   last;
        logic done;
        idx = model_hit(a);
        vda = 1'b1; rw = r; ad = a; ext_dat = 8'($urandom); ch_ack = 4'($urandom);
        #1;
        if (idx < 0) begin
            chk("miss_cs", 32'(cs), 32'h0);
            chk("miss_rdy", 32'(rdy), 32'h1);
            chk("miss_dat", 32'(dat_o), 32'(r ? ext_dat : 8'h00));
        end else begin
            chk("detect_rdy", 32'(rdy), 32'h0);
            chk("detect_cs", 32'(cs), 32'h0);
            done = 1'b0;
            k = 0;
            for (int w = int'(m_ws[idx]); w <= TMO; w++)
                if (!done && ack_bits[w]) begin
                    done = 1'b1;
                    k = w;
                end
            last = done ? k : TMO;
            for (int w = 0; w <= last; w++) begin
                tick();
                ch_ack = 4'($urandom);
                ch_ack[idx] = ack_bits[w];
                #1;
                chk("wait_cs", 32'(cs), 32'(1 << idx));
                chk("wait_rdy", 32'(rdy), 32'h0);
                chk("wait_err", 32'(err), 32'h0);
            end
            tick();
            if (done) begin
                chk("done_cs", 32'(cs), 32'(1 << idx));
                chk("done_rdy", 32'(rdy), 32'h1);
                chk("done_err", 32'(err), 32'h0);
                chk("done_dat", 32'(dat_o), 32'(r ? m_dat[idx] : 8'h00));
            end else begin
                chk("err_cs", 32'(cs), 32'h0);
                chk("err_rdy", 32'(rdy), 32'h1);
                chk("err_pulse", 32'(err), 32'h1);
                chk("err_dat", 32'(dat_o), 32'(r ? 8'hFF : 8'h00));
                chk("err_ad", 32'(err_ad), 32'(a));
            end
        end
        tick();
        vda = 1'b0;
        #1;
        chk("idle_rdy", 32'(rdy), 32'h1);
        chk("idle_cs", 32'(cs), 32'h0);
        chk("idle_err", 32'(err), 32'h0);
        if (idx >= 0 && !done) chk("err_ad_hold", 32'(err_ad), 32'(a));
    endtask

    vec_t          vecs [6];
    logic [AW-1:0] masks [4];

    initial begin
        int            c;
        logic [AW-1:0] a;
        logic [15:0]   ab;

        model_reset();
        for (int i = 0; i < NCH; i++) m_dat[i] = '0;
        masks[0] = 26'h3FFFFF0; masks[1] = 26'h3FFFF00;
        masks[2] = 26'h3FF0000; masks[3] = 26'h3FFFFFF;

        vecs[0] = '{1'b1, 1'b1, 26'h0000060, 8'h5A, 4'b0000, 1'b1, 8'h5A};
        vecs[1] = '{1'b1, 1'b1, 26'h0000060, 8'hA5, 4'b0000, 1'b1, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 26'h0000060, 8'h5A, 4'b0000, 1'b1, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 26'h3FFFFFF, 8'h3C, 4'b0000, 1'b1, 8'h3C};
        vecs[4] = '{1'b1, 1'b1, 26'h0000000, 8'hFF, 4'b0000, 1'b1, 8'hFF};
        vecs[5] = '{1'b0, 1'b0, 26'h1234567, 8'h77, 4'b0000, 1'b1, 8'h00};

        #1;
        chk("rst_cs", 32'(cs), 32'h0);
        chk("rst_rdy", 32'(rdy), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_ad", 32'(err_ad), 32'h0);
        chk("rst_dat", 32'(dat_o), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            vda = vecs[i].vda; rw = vecs[i].rw; ad = vecs[i].ad; ext_dat = vecs[i].ext;
            #1;
            chk("vec_cs", 32'(cs), 32'(vecs[i].exp_cs));
            chk("vec_rdy", 32'(rdy), 32'(vecs[i].exp_rdy));
            chk("vec_dat", 32'(dat_o), 32'(vecs[i].exp_dat));
            tick();
        end

        m_dat[1] = 8'hC3;
        cfg_write(1, 26'h60, 26'h3FFFFF0, 4'd0, 1'b1);
        run_access(26'h65, 1'b1, 16'hFFFF);
        cfg_write(1, 26'h60, 26'h3FFFFF0, 4'd3, 1'b1);
        run_access(26'h65, 1'b1, 16'hFFFF);
        m_dat[0] = 8'h11;
        cfg_write(0, 26'h64, 26'h3FFFFFC, 4'd0, 1'b1);
        run_access(26'h65, 1'b1, 16'hFFFF);
        cfg_write(0, 26'h0, 26'h0, 4'd0, 1'b0);

        m_dat[2] = 8'h9E;
        cfg_write(2, 26'h200, 26'h3FFFF00, 4'd0, 1'b1);
        run_access(26'h2AB, 1'b1, 16'h0000);
        run_access(26'h2AB, 1'b1, 16'h0100);
        run_access(26'h2AB, 1'b0, 16'h0000);
        run_access(26'h2AB, 1'b0, 16'h0004);

        cfg_write(1, 26'h60, 26'h3FFFFF0, 4'd2, 1'b1);
        vda = 1'b1; rw = 1'b1; ad = 26'h65; ch_ack = '0;
        #1;
        tick();
        chk("pre_rst_cs", 32'(cs), 32'h2);
        rst = 1'b1;
        #1;
        chk("async_rst_cs", 32'(cs), 32'h0);
        chk("async_rst_rdy", 32'(rdy), 32'h1);
        chk("async_rst_err_ad", 32'(err_ad), 32'h0);
        tick();
        rst = 1'b0;
        vda = 1'b0;
        model_reset();
        run_access(26'h65, 1'b1, 16'hFFFF);

        cfg_write(1, 26'h60, 26'h3FFFFF0, 4'd0, 1'b1);
        vda = 1'b1; rw = 1'b1; ad = 26'h65; ch_ack = '0; ext_dat = 8'h42;
        #1;
        chk("drop_detect_rdy", 32'(rdy), 32'h0);
        tick();
        tick();
        vda = 1'b0;
        #1;
        chk("drop_wait_cs", 32'(cs), 32'h2);
        chk("drop_wait_rdy", 32'(rdy), 32'h0);
        tick();
        chk("drop_idle_rdy", 32'(rdy), 32'h1);
        chk("drop_idle_cs", 32'(cs), 32'h0);
        chk("drop_idle_err", 32'(err), 32'h0);
        chk("drop_idle_dat", 32'(dat_o), 32'h42);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0)
                cfg_write(int'($urandom_range(0, NCH - 1)), 26'($urandom) & 26'h3FFFF00,
                          masks[$urandom_range(0, 3)], 4'($urandom_range(0, 3)),
                          $urandom_range(0, 3) != 0);
            for (int i = 0; i < NCH; i++) m_dat[i] = 8'($urandom);
            c = int'($urandom_range(0, NCH - 1));
            if ($urandom_range(0, 3) != 0) a = m_base[c] ^ (26'($urandom) & ~m_mask[c]);
            else a = 26'($urandom);
            case ($urandom_range(0, 3))
                0:       ab = 16'h0000;
                1:       ab = 16'hFFFF;
                default: ab = 16'($urandom & $urandom);
            endcase
            run_access(a, 1'($urandom), ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ft833_bus_decoder.md
Name: ft833_bus_decoder

Overview:
Parametrised successor to the fixed chip-select decode and read-data mux used in FT833 SoC tops. It decodes the CPU address into NCH runtime-programmable windows (base/mask/enable), each with its own wait-state count. It runs a per-access handshake with the selected peripheral, drives CPU `rdy`, and steers read data. Unacknowledged accesses time out into a bus-error cycle that captures the faulting address.

Parameters:
NCH, 4, number of peripheral channels (1..8)
AW, 26, address width
DW, 8, data width
WSW, 4, wait-state counter width
TMO, 255, timeout limit in WAIT cycles (1..2^16-1)
DEFAULT_WS, 0, wait-state value loaded into every channel at reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
vda  in  1  CPU valid data address
rw  in  1  1=read, 0=write
ad  in  AW  CPU physical address
cfg_we  in  1  configuration write strobe
cfg_ch  in  $clog2(NCH) (min 1)  channel being configured
cfg_base  in  AW  window base
cfg_mask  in  AW  window compare mask (1=bit compared)
cfg_ws  in  WSW  wait states
cfg_en  in  1  window enable
cs  out  NCH  one-hot channel select
ch_ack  in  NCH  per-channel ready/ack
ch_dat  in  NCH*DW  per-channel read data, channel i at [i*DW +: DW]
ext_dat  in  DW  external bus read data (no-hit path)
dat_o  out  DW  read data to CPU
rdy  out  1  CPU ready
err  out  1  one-cycle bus-error pulse
err_ad  out  AW  address of last timed-out access

Behaviour:
- Hit[i] = en[i] && (((ad ^ base[i]) & mask[i]) == 0).
  - Lowest index wins on overlap.
  - No hit (or vda=0) selects the external path.
- Config registers:
  - Written on the clk edge when cfg_we=1; cfg_ch>=NCH is ignored.
  - Updates affect decode from the next cycle only.
  - An access in progress keeps its latched channel and count.
- State machine: IDLE, WAIT, DONE, ERR. Reset forces IDLE from any state.
- IDLE:
  - cs=0 and rdy=1.
  - dat_o = rw ? ext_dat : 0.
  - On vda && any hit: latch ch = winning index, wcnt = ws[ch], tcnt = 0; go to WAIT.
  - rdy is combinationally 0 in that cycle.
- WAIT:
  - cs[ch]=1, rdy=0.
  - wcnt decrements to 0 and holds there.
  - tcnt increments every cycle.
  - If wcnt==0 && ch_ack[ch]: capture dat_r = rw ? ch_dat[ch] : 0, go to DONE.
  - Else if tcnt==TMO: go to ERR. Ack beats timeout when both occur in the same cycle.
  - If vda falls: return to IDLE with no err and no data.
- DONE:
  - cs[ch]=1, rdy=1, dat_o=dat_r for exactly one cycle, then IDLE.
- ERR:
  - rdy=1, err=1, cs=0.
  - dat_o = all-ones when rw=1, otherwise 0.
  - err_ad <= latched access address; then IDLE.
- Minimum hit latency (ws=0, ack held high): rdy low for 2 cycles (IDLE-detect and WAIT), data in the DONE cycle.
- ws=N adds N cycles. Timeout occurs TMO+1 cycles after entering WAIT.
- ch_ack from unselected channels is ignored.
- Write cycles use the same flow; dat_o is 0.
- Reset values:
  - Outputs: cs=0, rdy=1, err=0, err_ad=0, dat_o=0 (rw sampled after reset).
  - Config: all en=0, base=0, mask=0, ws=DEFAULT_WS. After reset every access goes external.

Test Plan:
- Reset, vda=1, rw=1, ad=26'h0000060, ext_dat=8'h5A -> cs=0, rdy=1, dat_o=8'h5A every cycle.
- Configure ch1 base=26'h60, mask=26'h3FFFFF0, ws=0, en=1; ch_ack[1]=1, ch_dat[1]=8'hC3; read ad=26'h65 -> rdy low 2 cycles, cs=4'b0010, then DONE with rdy=1 and dat_o=8'hC3 for one cycle.
- Same window with ws=3 -> rdy low 5 cycles. Then with ch0 also covering 26'h65 -> cs=4'b0001 (lowest index wins).
- Hit ch2 with ch_ack[2]=0, TMO=8 -> 9 WAIT cycles, then err=1 for one cycle, rdy=1, dat_o=8'hFF, err_ad=accessed address, back to IDLE.
- Ack and timeout in the same cycle -> DONE taken, err stays 0.
- Assert rst during WAIT -> cs=0 and rdy=1 immediately, config registers cleared; after rst=0, vda drop mid-WAIT -> return to IDLE, err=0.
